// File: rtl/msx_slot_pkg.sv
// rtl/msx_slot_pkg.sv - shared state type and default timing for the MSX slot initiator
package msx_slot_pkg;

  // Reference clock is 21.47727 MHz; dividing by 6 gives the 3.58 MHz Z80 T-state.
  localparam int CLK_DIV_DEFAULT     = 6;
  localparam int WAIT_STATES_DEFAULT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TW,
    ST_T3
  } state_t;

endpackage

// File: rtl/msx_tstate_timer.sv
// rtl/msx_tstate_timer.sv - clk-within-T-state counter with half/pre_half/last strobes
module msx_tstate_timer
  import msx_slot_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic nreset,
  input  logic restart,
  output logic half,
  output logic pre_half,
  output logic last
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (restart || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign half     = (cnt == CW'(CLK_DIV / 2));
  assign pre_half = (cnt == CW'(CLK_DIV / 2 - 1));
  assign last     = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/msx_slot_initiator.sv
// rtl/msx_slot_initiator.sv - Z80-timed MSX slot bus master; SLOT_NWAIT_EN adds slot_nwait stretching
module msx_slot_initiator
  import msx_slot_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEFAULT,
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        int_n,
  output logic        slot_nreset,
  output logic [15:0] slot_a,
  inout  wire  [7:0]  slot_d,
  output logic        slot_nsltsl,
  output logic        slot_nmerq,
  output logic        slot_nrd,
  output logic        slot_nwr,
  input  logic        slot_nint
`ifdef SLOT_NWAIT_EN
  ,
  input  logic        slot_nwait
`endif
);

  state_t     state;
  logic       is_wr;
  logic [7:0] dout;
  logic       d_oe;
  logic [1:0] tw_left;
  logic       nint_meta;
  logic       accept;
  logic       ext;
  logic       pre_half;
  logic       last;
  logic       timer_half_unused;
  logic [2:0] tw_total;
  logic [2:0] tw_more;

  assign accept = (state == ST_IDLE) && req;

  msx_tstate_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .nreset   (nreset),
    .restart  (accept),
    .half     (timer_half_unused),
    .pre_half (pre_half),
    .last     (last)
  );

`ifdef SLOT_NWAIT_EN
  logic [1:0] nwait_sync;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nwait_sync <= 2'b11;
    end else begin
      nwait_sync <= {nwait_sync[0], slot_nwait};
    end
  end

  assign ext = ~nwait_sync[1];
`else
  assign ext = 1'b0;
`endif

  // tw_left counts TW states still owed after the current one.
  assign tw_total = 3'(WAIT_STATES) + {2'b00, ext};
  assign tw_more  = {1'b0, tw_left} + {2'b00, ext};

  // Outputs are registered one clk early so each appears on its nominal clk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      ack         <= 1'b0;
      rdata       <= 8'h00;
      slot_a      <= 16'h0000;
      dout        <= 8'h00;
      d_oe        <= 1'b0;
      is_wr       <= 1'b0;
      tw_left     <= 2'd0;
      slot_nsltsl <= 1'b1;
      slot_nmerq  <= 1'b1;
      slot_nrd    <= 1'b1;
      slot_nwr    <= 1'b1;
    end else begin
      ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            state  <= ST_T1;
            busy   <= 1'b1;
            is_wr  <= wr;
            slot_a <= addr;
            dout   <= wdata;
            d_oe   <= wr;
          end
        end
        ST_T1: begin
          if (pre_half) begin
            slot_nsltsl <= 1'b0;
            slot_nmerq  <= 1'b0;
            slot_nrd    <= is_wr;
          end
          if (last) begin
            state    <= ST_T2;
            slot_nwr <= ~is_wr;
          end
        end
        ST_T2: begin
          if (last) begin
            if (tw_total == 3'd0) begin
              state <= ST_T3;
            end else begin
              state   <= ST_TW;
              tw_left <= 2'(tw_total - 3'd1);
            end
          end
        end
        ST_TW: begin
          if (last) begin
            if (tw_more == 3'd0) begin
              state <= ST_T3;
            end else begin
              tw_left <= 2'(tw_more - 3'd1);
            end
          end
        end
        ST_T3: begin
          if (pre_half) begin
            if (!is_wr) begin
              rdata <= slot_d;
            end
            slot_nsltsl <= 1'b1;
            slot_nmerq  <= 1'b1;
            slot_nrd    <= 1'b1;
            slot_nwr    <= 1'b1;
          end
          if (last) begin
            state <= ST_IDLE;
            ack   <= 1'b1;
            busy  <= 1'b0;
            d_oe  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign slot_d = d_oe ? dout : 8'bz;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_nreset <= 1'b0;
      nint_meta   <= 1'b1;
      int_n       <= 1'b1;
    end else begin
      slot_nreset <= 1'b1;
      nint_meta   <= slot_nint;
      int_n       <= nint_meta;
    end
  end

endmodule

// File: tb/tb_msx_slot_initiator.sv
// tb/tb_msx_slot_initiator.sv - directed bench for msx_slot_initiator; SLOT_NWAIT_EN enables the wait test
module tb_msx_slot_initiator;

  logic        clk = 1'b0;
  logic        nreset, req, req_w0, req_w3, wr, slot_nint, probe_en;
  logic [15:0] addr;
  logic [7:0]  wdata;
`ifdef SLOT_NWAIT_EN
  logic        slot_nwait;
`endif

  logic        busy, ack, int_n, slot_nreset, nsltsl, nmerq, nrd, nwr;
  logic [7:0]  rdata;
  logic [15:0] slot_a;
  wire  [7:0]  slot_d;

  logic        busy_w0, ack_w0, int_n_w0, slot_nreset_w0, nsltsl_w0, nmerq_w0, nrd_w0, nwr_w0;
  logic [7:0]  rdata_w0;
  logic [15:0] slot_a_w0;
  wire  [7:0]  slot_d_w0;

  logic        busy_w3, ack_w3, int_n_w3, slot_nreset_w3, nsltsl_w3, nmerq_w3, nrd_w3, nwr_w3;
  logic [7:0]  rdata_w3;
  logic [15:0] slot_a_w3;
  wire  [7:0]  slot_d_w3;

  int n_vec = 0;
  int n_bad = 0;
  int acks;

  logic        s_ack[64], s_busy[64], s_nsltsl[64], s_nmerq[64], s_nrd[64], s_nwr[64];
  logic        s_ack0[64], s_ack3[64];
  logic [7:0]  s_d[64], s_rdata[64], s_rdata0[64];
  logic [15:0] s_a[64];

  always #5 clk = ~clk;

  // Cartridge responder returns C3 on reads; probe_en pulls the bus to A5 to prove it floats.
  assign slot_d    = !nrd     ? 8'hC3 : 8'bz;
  assign slot_d    = probe_en ? 8'hA5 : 8'bz;
  assign slot_d_w0 = !nrd_w0  ? 8'hC3 : 8'bz;
  assign slot_d_w3 = !nrd_w3  ? 8'hC3 : 8'bz;

  msx_slot_initiator #(.CLK_DIV(6), .WAIT_STATES(1)) dut (
    .clk(clk), .nreset(nreset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .int_n(int_n), .slot_nreset(slot_nreset),
    .slot_a(slot_a), .slot_d(slot_d), .slot_nsltsl(nsltsl), .slot_nmerq(nmerq),
    .slot_nrd(nrd), .slot_nwr(nwr), .slot_nint(slot_nint)
`ifdef SLOT_NWAIT_EN
    , .slot_nwait(slot_nwait)
`endif
  );

  msx_slot_initiator #(.CLK_DIV(6), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .nreset(nreset), .req(req_w0), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy_w0), .ack(ack_w0), .rdata(rdata_w0), .int_n(int_n_w0), .slot_nreset(slot_nreset_w0),
    .slot_a(slot_a_w0), .slot_d(slot_d_w0), .slot_nsltsl(nsltsl_w0), .slot_nmerq(nmerq_w0),
    .slot_nrd(nrd_w0), .slot_nwr(nwr_w0), .slot_nint(slot_nint)
`ifdef SLOT_NWAIT_EN
    , .slot_nwait(slot_nwait)
`endif
  );

  msx_slot_initiator #(.CLK_DIV(6), .WAIT_STATES(3)) dut_w3 (
    .clk(clk), .nreset(nreset), .req(req_w3), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy_w3), .ack(ack_w3), .rdata(rdata_w3), .int_n(int_n_w3), .slot_nreset(slot_nreset_w3),
    .slot_a(slot_a_w3), .slot_d(slot_d_w3), .slot_nsltsl(nsltsl_w3), .slot_nmerq(nmerq_w3),
    .slot_nrd(nrd_w3), .slot_nwr(nwr_w3), .slot_nint(slot_nint)
`ifdef SLOT_NWAIT_EN
    , .slot_nwait(slot_nwait)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call #1 after an edge; the next edge is the acceptance edge and period k follows edge k.
  task automatic run_txn(input logic t_wr, input logic [15:0] t_addr, input logic [7:0] t_wdata,
                         input int n, input bit hold_req, input bit nwait_pulse);
    wr = t_wr; addr = t_addr; wdata = t_wdata; req = 1'b1;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      s_ack[k] = ack;       s_busy[k] = busy;     s_nsltsl[k] = nsltsl; s_nmerq[k] = nmerq;
      s_nrd[k] = nrd;       s_nwr[k] = nwr;       s_d[k] = slot_d;      s_rdata[k] = rdata;
      s_a[k] = slot_a;      s_ack0[k] = ack_w0;   s_ack3[k] = ack_w3;   s_rdata0[k] = rdata_w0;
      if (k == 0 && !hold_req) begin req = 1'b0; req_w0 = 1'b0; req_w3 = 1'b0; end
      if (k == 5) begin addr = 16'h1234; wdata = 8'hFF; end
      if (k == 30) req = 1'b0;
`ifdef SLOT_NWAIT_EN
      if (nwait_pulse && k == 6)  slot_nwait = 1'b0;
      if (nwait_pulse && k == 16) slot_nwait = 1'b1;
`else
      if (nwait_pulse && k == 6) $display("note: wait pulse requested without slot_nwait");
`endif
    end
  endtask

  initial begin
    nreset = 1'b0; req = 1'b0; req_w0 = 1'b0; req_w3 = 1'b0; wr = 1'b0;
    addr = 16'h0; wdata = 8'h0; slot_nint = 1'b1; probe_en = 1'b0;
`ifdef SLOT_NWAIT_EN
    slot_nwait = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ack", ack, 1'b0);
    check_eq("rst_rdata", rdata, 8'h00);
    check_eq("rst_int_n", int_n, 1'b1);
    check_eq("rst_slot_nreset", slot_nreset, 1'b0);
    check_eq("rst_slot_a", slot_a, 16'h0000);
    check_eq("rst_strobes", {nsltsl, nmerq, nrd, nwr}, 4'hF);
    probe_en = 1'b1; #1;
    check_eq("rst_slot_d_float", slot_d, 8'hA5);
    probe_en = 1'b0;
    nreset = 1'b1;
    @(posedge clk); #1;
    check_eq("slot_nreset_release", slot_nreset, 1'b1);

    // Reset in the middle of T2 of a write.
    wr = 1'b1; addr = 16'h9800; wdata = 8'h5A; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check_eq("midrst_pre_nwr", nwr, 1'b0);
    nreset = 1'b0; #1;
    check_eq("midrst_strobes", {nsltsl, nmerq, nrd, nwr}, 4'hF);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_slot_nreset", slot_nreset, 1'b0);
    probe_en = 1'b1; #1;
    check_eq("midrst_slot_d_float", slot_d, 8'hA5);
    probe_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check_eq("midrst_no_ack", acks, 0);
    check_eq("midrst_idle_busy", busy, 1'b0);

    // Write 5A to 9800; addr/wdata change at clk 5 must be ignored.
    run_txn(1'b1, 16'h9800, 8'h5A, 26, 1'b0, 1'b0);
    check_eq("wr_busy0", s_busy[0], 1'b1);
    check_eq("wr_nsltsl2", s_nsltsl[2], 1'b1);
    check_eq("wr_nsltsl3", s_nsltsl[3], 1'b0);
    check_eq("wr_nmerq3", s_nmerq[3], 1'b0);
    check_eq("wr_nwr5", s_nwr[5], 1'b1);
    check_eq("wr_nwr6", s_nwr[6], 1'b0);
    check_eq("wr_nwr12", s_nwr[12], 1'b0);
    check_eq("wr_nwr20", s_nwr[20], 1'b0);
    check_eq("wr_nwr21", s_nwr[21], 1'b1);
    check_eq("wr_nsltsl21", s_nsltsl[21], 1'b1);
    check_eq("wr_nrd10", s_nrd[10], 1'b1);
    check_eq("wr_d0", s_d[0], 8'h5A);
    check_eq("wr_d23", s_d[23], 8'h5A);
    check_eq("wr_a10", s_a[10], 16'h9800);
    check_eq("wr_ack23", s_ack[23], 1'b0);
    check_eq("wr_ack24", s_ack[24], 1'b1);
    check_eq("wr_busy24", s_busy[24], 1'b0);
    check_eq("wr_ack25", s_ack[25], 1'b0);
    probe_en = 1'b1; #1;
    check_eq("wr_slot_d_released", slot_d, 8'hA5);
    probe_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Read 9880 on all three instances at once.
    req_w0 = 1'b1; req_w3 = 1'b1;
    run_txn(1'b0, 16'h9880, 8'h00, 40, 1'b0, 1'b0);
    check_eq("rd_nrd2", s_nrd[2], 1'b1);
    check_eq("rd_nrd3", s_nrd[3], 1'b0);
    check_eq("rd_nrd20", s_nrd[20], 1'b0);
    check_eq("rd_nrd21", s_nrd[21], 1'b1);
    check_eq("rd_nwr10", s_nwr[10], 1'b1);
    check_eq("rd_rdata20", s_rdata[20], 8'h00);
    check_eq("rd_rdata24", s_rdata[24], 8'hC3);
    check_eq("rd_ack24", s_ack[24], 1'b1);
    check_eq("w0_ack17", s_ack0[17], 1'b0);
    check_eq("w0_ack18", s_ack0[18], 1'b1);
    check_eq("w0_rdata18", s_rdata0[18], 8'hC3);
    check_eq("w3_ack35", s_ack3[35], 1'b0);
    check_eq("w3_ack36", s_ack3[36], 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back writes with req held; second one takes the addr/wdata changed at clk 5.
    run_txn(1'b1, 16'h9800, 8'h5A, 52, 1'b1, 1'b0);
    check_eq("b2b_ack24", s_ack[24], 1'b1);
    check_eq("b2b_a24", s_a[24], 16'h9800);
    check_eq("b2b_nsltsl27", s_nsltsl[27], 1'b1);
    check_eq("b2b_nsltsl28", s_nsltsl[28], 1'b0);
    check_eq("b2b_a26", s_a[26], 16'h1234);
    check_eq("b2b_d30", s_d[30], 8'hFF);
    check_eq("b2b_ack48", s_ack[48], 1'b0);
    check_eq("b2b_ack49", s_ack[49], 1'b1);
    check_eq("b2b_rdata_held", s_rdata[49], 8'hC3);
    repeat (3) @(posedge clk);
    #1;

`ifdef SLOT_NWAIT_EN
    run_txn(1'b1, 16'h9800, 8'h5A, 40, 1'b0, 1'b1);
    check_eq("nwait_nwr30", s_nwr[30], 1'b0);
    check_eq("nwait_ack24", s_ack[24], 1'b0);
    check_eq("nwait_ack35", s_ack[35], 1'b0);
    check_eq("nwait_ack36", s_ack[36], 1'b1);
    repeat (3) @(posedge clk);
    #1;
`endif

    slot_nint = 1'b0;
    @(posedge clk); #1;
    check_eq("int_n_sync1", int_n, 1'b1);
    @(posedge clk); #1;
    check_eq("int_n_sync2", int_n, 1'b0);
    slot_nint = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("int_n_release", int_n, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
